// File: rtl/ssm_vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssm_vga_pkg
//  Description : Shared widths, SRAM slot states and colour field layout for
//                the frame-buffer SRAM reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package ssm_vga_pkg;

  localparam int ADDR_W  = 18;   // 9-bit X + 9-bit Y word address
  localparam int DATA_W  = 16;

  // Colour fields inside one SRAM word; low nibble is unused padding
  localparam int R_MSB   = 15;
  localparam int G_MSB   = 11;
  localparam int B_MSB   = 7;
  localparam int FIELD_W = 4;
  localparam int PAD_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_wr_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sram_wr_buffer
//  Description : One-entry valid/ready holding register for pixel-writer
//                requests. Ready is registered and equals ~pend.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_wr_buffer #(
  parameter int ADDR_W = ssm_vga_pkg::ADDR_W,
  parameter int DATA_W = ssm_vga_pkg::DATA_W
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iWr_valid,
  input  logic [ADDR_W-1:0] iWr_addr,
  input  logic [DATA_W-1:0] iWr_data,
  input  logic              iIssue,
  output logic              oWr_ready,
  output logic              oPend,
  output logic [ADDR_W-1:0] oAddr,
  output logic [DATA_W-1:0] oData
);

  logic              r_pend;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // Capture a request on transfer; free the entry on the edge it is issued,
  // since the SRAM data/address registers take their copy on that same edge.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_pend  <= 1'b0;
      r_ready <= 1'b1;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (iIssue) begin
      r_pend  <= 1'b0;
      r_ready <= 1'b1;
    end else if (iWr_valid && r_ready) begin
      r_pend  <= 1'b1;
      r_ready <= 1'b0;
      r_addr  <= iWr_addr;
      r_data  <= iWr_data;
    end
  end

  assign oWr_ready = r_ready;
  assign oPend     = r_pend;
  assign oAddr     = r_addr;
  assign oData     = r_data;

endmodule
`default_nettype wire

// File: rtl/sram_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : sram_frame_reader
//  Description : Time-slots a 16-bit async SRAM between 2x2-doubled VGA
//                scan-out reads (even X in active video) and pixel-writer
//                requests (odd X and blanking). Unpacks read words into
//                10-bit R/G/B.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_frame_reader #(
  parameter int          ADDR_W    = ssm_vga_pkg::ADDR_W,
  parameter int          DATA_W    = ssm_vga_pkg::DATA_W,
  parameter logic [29:0] BLANK_RGB = 30'h0
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [9:0]        iCoord_X,
  input  logic [9:0]        iCoord_Y,
  input  logic              iActive,
  input  logic              iWr_valid,
  input  logic [ADDR_W-1:0] iWr_addr,
  input  logic [DATA_W-1:0] iWr_data,
  output logic              oWr_ready,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic [DATA_W-1:0] oSRAM_DQ,
  output logic              oSRAM_DQ_OE,
  input  logic [DATA_W-1:0] iSRAM_DQ,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N,
  output logic [9:0]        oRed,
  output logic [9:0]        oGreen,
  output logic [9:0]        oBlue,
  output logic              oPix_valid
);

  import ssm_vga_pkg::*;

  state_t            r_state, w_state_nxt;
  logic              w_rd_slot;
  logic              w_issue;
  logic              w_pend;
  logic [ADDR_W-1:0] w_buf_addr;
  logic [DATA_W-1:0] w_buf_data;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_dq, w_dq_nxt;
  logic              r_we_n, w_we_n_nxt;
  logic              r_oe_n, w_oe_n_nxt;
  logic              r_dq_oe, w_dq_oe_nxt;
  logic              r_act_d1;
  logic              r_pix_valid;
  logic [29:0]       r_rgb;
  logic [29:0]       w_rgb_word;
  logic              w_unused_bits;

  // Even X in the visible region belongs to scan-out; everything else may write
  assign w_rd_slot = iActive & ~iCoord_X[0];
  assign w_issue   = ~w_rd_slot & w_pend;

  sram_wr_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_buffer (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iWr_valid (iWr_valid),
    .iWr_addr  (iWr_addr),
    .iWr_data  (iWr_data),
    .iIssue    (w_issue),
    .oWr_ready (oWr_ready),
    .oPend     (w_pend),
    .oAddr     (w_buf_addr),
    .oData     (w_buf_data)
  );

  // Next slot and its SRAM pin values; read and write are exclusive by state
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_addr_nxt  = r_addr;
    w_dq_nxt    = r_dq;
    w_we_n_nxt  = 1'b1;
    w_oe_n_nxt  = 1'b1;
    w_dq_oe_nxt = 1'b0;
    if (w_rd_slot) begin
      w_state_nxt = ST_READ;
      w_addr_nxt  = {iCoord_X[9:1], iCoord_Y[9:1]};
      w_oe_n_nxt  = 1'b0;
    end else if (w_pend) begin
      w_state_nxt = ST_WRITE;
      w_addr_nxt  = w_buf_addr;
      w_dq_nxt    = w_buf_data;
      w_we_n_nxt  = 1'b0;
      w_dq_oe_nxt = 1'b1;
    end
  end

  // State and SRAM pins are all registered; reset forces WE_N high at once
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_dq    <= '0;
      r_we_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_dq_oe <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_dq    <= w_dq_nxt;
      r_we_n  <= w_we_n_nxt;
      r_oe_n  <= w_oe_n_nxt;
      r_dq_oe <= w_dq_oe_nxt;
    end
  end

  // Nibble fields widened to 10 bits by zero padding below the MSBs
  assign w_rgb_word = {iSRAM_DQ[R_MSB -: FIELD_W], {PAD_W{1'b0}},
                       iSRAM_DQ[G_MSB -: FIELD_W], {PAD_W{1'b0}},
                       iSRAM_DQ[B_MSB -: FIELD_W], {PAD_W{1'b0}}};
  assign w_unused_bits = ^{iSRAM_DQ[B_MSB-FIELD_W:0], iCoord_Y[0]};

  // Sample read data at the end of a read slot and hold it across the odd-X
  // cycle so each word covers its pixel pair; blank outside active video
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_act_d1    <= 1'b0;
      r_pix_valid <= 1'b0;
      r_rgb       <= BLANK_RGB;
    end else begin
      r_act_d1    <= iActive;
      r_pix_valid <= r_act_d1;
      if (r_state == ST_READ) begin
        r_rgb <= w_rgb_word;
      end else if (!r_act_d1) begin
        r_rgb <= BLANK_RGB;
      end
    end
  end

  assign oSRAM_ADDR  = r_addr;
  assign oSRAM_DQ    = r_dq;
  assign oSRAM_DQ_OE = r_dq_oe;
  assign oSRAM_WE_N  = r_we_n;
  assign oSRAM_OE_N  = r_oe_n;
  assign oRed        = r_rgb[29:20];
  assign oGreen      = r_rgb[19:10];
  assign oBlue       = r_rgb[9:0];
  assign oPix_valid  = r_pix_valid;

endmodule
`default_nettype wire

// File: doc/sram_frame_reader.md
Name: sram_frame_reader

Overview:
- SRAM-side responder for the frame buffer.
- Serves two clients on the shared 16-bit async SRAM:
  - VGA scan-out reads, addressed by the VGA controller's Coord_X/Coord_Y, with pixels doubled 2x2.
  - Pixel-writer requests, from the walker/drawing logic, over a valid/ready handshake.
- Reads own even-X slots during active video. Writes use odd-X slots and all blanking cycles.
- Unpacks each SRAM word into 10-bit R/G/B for the VGA controller.

Parameters:
- ADDR_W, 18, SRAM word address width = 9-bit X + 9-bit Y.
- DATA_W, 16, SRAM data width.
- BLANK_RGB, 30'h0, {R,G,B} driven when no valid pixel is present.

Ports:
- iCLK  in  1  VGA control clock; the only clock.
- iRST_N  in  1  Asynchronous, active-low reset.
- iCoord_X  in  10  Current VGA X coordinate.
- iCoord_Y  in  10  Current VGA Y coordinate.
- iActive  in  1  Coordinates are in the visible region.
- iWr_valid  in  1  Writer request.
- iWr_addr  in  ADDR_W  Write address {x[8:0], y[8:0]}.
- iWr_data  in  DATA_W  Write data.
- oWr_ready  out  1  Write buffer empty; request can be accepted.
- oSRAM_ADDR  out  ADDR_W  Registered SRAM address.
- oSRAM_DQ  out  DATA_W  Write data.
- oSRAM_DQ_OE  out  1  Top level drives SRAM_DQ when 1, otherwise hi-Z.
- iSRAM_DQ  in  DATA_W  SRAM read data.
- oSRAM_WE_N  out  1  Registered SRAM write enable, active low.
- oSRAM_OE_N  out  1  Registered SRAM output enable, active low.
- oRed  out  10  Pixel red.
- oGreen  out  10  Pixel green.
- oBlue  out  10  Pixel blue.
- oPix_valid  out  1  Qualifies oRed/oGreen/oBlue.

Behaviour:
- Reset (async assert, sync release):
  - pend=0, oWr_ready=1.
  - oSRAM_WE_N=1, oSRAM_OE_N=1, oSRAM_DQ_OE=0, oSRAM_ADDR=0, oSRAM_DQ=0.
  - RGB=BLANK_RGB, oPix_valid=0, state=ST_IDLE.
- Slot decode, made on cycle N from the inputs:
  - rd_slot = iActive & ~iCoord_X[0].
  - wr_slot = ~rd_slot.
- State for cycle N+1; all SRAM outputs registered, no combinational path to pins:
  - ST_READ if rd_slot:
    - ADDR = {iCoord_X[9:1], iCoord_Y[9:1]}.
    - OE_N=0, WE_N=1, DQ_OE=0.
  - ST_WRITE if wr_slot & pend:
    - ADDR = buffered addr, DQ = buffered data.
    - WE_N=0, OE_N=1, DQ_OE=1.
    - pend clears at the end of that cycle.
  - ST_IDLE otherwise: OE_N=1, WE_N=1, DQ_OE=0.
- Turnaround:
  - A write is never issued in the cycle directly preceding a read in a way that lets DQ_OE and OE_N=0 overlap; they are exclusive by state.
  - WE_N is high in every non-write cycle.
- Write handshake, via a one-entry buffer:
  - oWr_ready = ~pend, registered.
  - A transfer occurs when iWr_valid & oWr_ready at a rising edge; addr and data are latched and pend=1.
  - No acceptance while pend.
  - Throughput: 1 write per 2 clocks in active video, 1 per 2 clocks in blanking (accept cycle then issue cycle).
  - Data, address and valid must stay stable only until the transfer.
- Read return:
  - A read issued in cycle N+1 is sampled from iSRAM_DQ at the end of N+1.
  - RGB is registered and valid from N+2, held for 2 clocks (the pixel pair).
  - Total latency from coordinate to RGB = 2 clocks; the VGA controller compensates.
- Unpacking (DQ[3:0] ignored):
  - R = {DQ[15:12], 6'b0}.
  - G = {DQ[11:8], 6'b0}.
  - B = {DQ[7:4], 6'b0}.
- oPix_valid mirrors the delayed iActive. RGB = BLANK_RGB whenever oPix_valid=0.
- Same-address conflict: no forwarding. A read sees SRAM contents at its slot. A write landing after it is visible next frame.
- Reset mid-write: the pending request is discarded, WE_N returns high immediately (async), and the writer must re-issue.
- Coordinate wrap (X 639→0, Y 479→0) needs no special handling; the slot rule is purely combinational on the inputs.

Decomposition:
- Package ssm_vga_pkg:
  - ADDR_W, DATA_W.
  - state enum ST_IDLE, ST_READ, ST_WRITE.
  - Colour field bit positions (R_MSB=15, G_MSB=11, B_MSB=7, field width 4, pad 6).
- Sub-module sram_wr_buffer: one-entry valid/ready holding register with a pend flag and an issue/clear input.

Test Plan:
- Reset:
  - Stimulus: assert iRST_N=0 mid-frame with pend=1.
  - Required: within the same cycle WE_N=1, DQ_OE=0, oWr_ready=1, RGB=0, oPix_valid=0.
- Scan-out read:
  - Stimulus: iActive=1, X=10, Y=6; model SRAM word @{9'd5,9'd3}=16'hA5C0.
  - Required: next cycle ADDR=18'h00A03 with OE_N=0. Two cycles later R=10'h280, G=10'h140, B=10'h300, held for 2 clocks.
- Write in active video:
  - Stimulus: valid with addr 18'h12345, data 16'hF0F0, presented at even X.
  - Required: accepted (ready falls). The write is issued only in the cycle after an odd-X coordinate, with WE_N=0 and DQ_OE=1 for exactly one clock. The model SRAM holds F0F0.
- Blanking burst:
  - Stimulus: iActive=0; writer streams 8 back-to-back requests.
  - Required: 8 writes complete in 16 clocks, no OE_N=0 cycles, WE_N never low in two consecutive cycles.
- Contention:
  - Stimulus: write to {x=5,y=3} while the reader is scanning that pixel.
  - Required: the current frame shows the old value, the next frame shows the new value. DQ_OE and ~OE_N are never simultaneously 1 (assertion over the full frame).
- Back-pressure:
  - Stimulus: hold iWr_valid=1 with changing data while pend.
  - Required: only the accepted beat is written, and ready re-asserts the cycle after issue.
